// File: rtl/inst_loader_if.sv
// Byte-stream input handshake and instruction-memory write port of the boot loader.
interface inst_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  // master: the byte source / memory side (testbench or boot ROM glue)
  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  // slave: the loader itself
  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/inst_loader.sv
// Boot-time program loader: length header, little-endian instruction bytes, XOR checksum.
// Writes words into instruction memory and holds the core in reset until the image verifies.
module inst_loader #(
  parameter int MEM_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  inst_loader_if.slave     bus,
  output logic             core_hold,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [1:0]       idx;
  logic [23:0]      asm_reg;
  logic [7:0]       csum;

  logic             accept;
  logic [15:0]      hdr;
  logic [31:0]      addr_next;
  logic [CNT_W-1:0] wl_inc;

  always_comb begin
    bus.in_ready = 1'b0;
    if (rst) begin
      case (state)
        S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: bus.in_ready = 1'b1;
        default:                            bus.in_ready = 1'b0;
      endcase
    end
  end

  assign accept    = bus.in_valid && bus.in_ready;
  assign hdr       = {bus.in_data, count[7:0]};
  assign addr_next = 32'(words_loaded) << 2;
  assign wl_inc    = words_loaded + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_LEN_LO;
      count        <= '0;
      idx          <= '0;
      asm_reg      <= '0;
      csum         <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      core_hold    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        S_LEN_LO: if (accept) begin
          count <= CNT_W'(bus.in_data);
          state <= S_LEN_HI;
        end
        S_LEN_HI: if (accept) begin
          count <= CNT_W'(hdr);
          if (hdr > 16'(MEM_DEPTH)) begin
            err   <= 1'b1;
            state <= S_ERR;
          end else if (hdr == 16'd0) begin
            state <= S_CSUM;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (accept) begin
          csum <= csum ^ bus.in_data;
          idx  <= idx + 2'd1;
          case (idx)
            2'd0: asm_reg[7:0]   <= bus.in_data;
            2'd1: asm_reg[15:8]  <= bus.in_data;
            2'd2: asm_reg[23:16] <= bus.in_data;
            default: begin
              // last byte goes straight into the write word: one-cycle issue latency
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= addr_next;
              bus.wr_data <= {bus.in_data, asm_reg};
              state       <= S_WRITE;
            end
          endcase
        end
        S_WRITE: begin
          bus.wr_en    <= 1'b0;
          words_loaded <= wl_inc;
          state        <= (wl_inc == count) ? S_CSUM : S_DATA;
        end
        S_CSUM: if (accept) begin
          if (bus.in_data == csum) begin
            done      <= 1'b1;
            core_hold <= 1'b0;
            state     <= S_DONE;
          end else begin
            err   <= 1'b1;
            state <= S_ERR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: expected writes go into a scoreboard queue,
// a negedge monitor pops and compares them; end-of-load status is checked per scenario.
module tb_inst_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_hold, done, err;
  logic [15:0] words_loaded;

  inst_loader_if bus();

  inst_loader #(.MEM_DEPTH(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .core_hold(core_hold), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // monitor: scoreboard pop plus per-cycle invariants
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("hold_vs_done", {31'd0, core_hold}, {31'd0, ~done});
      chk("done_err_excl", {31'd0, done & err}, 32'd0);
      if (bus.wr_en) begin
        chk("wr_pulse", {31'd0, prev_wr}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_wr_addr", bus.wr_addr, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", bus.wr_addr, e.addr);
          chk("wr_data", bus.wr_data, e.data);
        end
      end
      prev_wr = bus.wr_en;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_wr_en"},     {31'd0, bus.wr_en},    32'd0);
    chk({tag, "_wr_addr"},   bus.wr_addr,           32'd0);
    chk({tag, "_wr_data"},   bus.wr_data,           32'd0);
    chk({tag, "_core_hold"}, {31'd0, core_hold},    32'd1);
    chk({tag, "_done"},      {31'd0, done},         32'd0);
    chk({tag, "_err"},       {31'd0, err},          32'd0);
    chk({tag, "_words"},     {16'd0, words_loaded}, 32'd0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    @(negedge clk);
  endtask

  // called at a negedge; returns at a negedge after the byte was accepted
  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int n = 0;
    if (toggle) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit toggle);
    foreach (s[i]) send_byte(s[i], toggle);
  endtask

  task automatic end_check(input string tag, input bit e_done, input bit e_err, input logic [15:0] e_wl);
    repeat (3) @(negedge clk);
    chk({tag, "_done"},      {31'd0, done},         {31'd0, e_done});
    chk({tag, "_err"},       {31'd0, err},          {31'd0, e_err});
    chk({tag, "_core_hold"}, {31'd0, core_hold},    {31'd0, ~e_done});
    chk({tag, "_words"},     {16'd0, words_loaded}, {16'd0, e_wl});
    chk({tag, "_in_ready"},  {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_q_empty"},   exp_q.size(),          32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    logic [7:0] v;

    // 1: single word, in_valid held high
    do_reset();
    exp_q.push_back('{32'd0, 32'h0050_0513});
    s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h46};
    send_stream(s, 1'b0);
    end_check("one_word", 1'b1, 1'b0, 16'd1);

    // 2: two words, in_valid toggling
    do_reset();
    exp_q.push_back('{32'd0, 32'h0050_0293});
    exp_q.push_back('{32'd4, 32'h0062_8333});
    s = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00, 8'h33, 8'h83, 8'h62, 8'h00, 8'h13};
    send_stream(s, 1'b1);
    end_check("two_words", 1'b1, 1'b0, 16'd2);

    // 3: empty image
    do_reset();
    s = '{8'h00, 8'h00, 8'h00};
    send_stream(s, 1'b0);
    end_check("empty", 1'b1, 1'b0, 16'd0);

    // 4: oversize header, ERR right after second byte
    do_reset();
    s = '{8'h41, 8'h00};
    send_stream(s, 1'b0);
    chk("oversize_err_now",   {31'd0, err},          32'd1);
    chk("oversize_ready_now", {31'd0, bus.in_ready}, 32'd0);
    end_check("oversize", 1'b0, 1'b1, 16'd0);

    // 5: bad checksum after a valid write
    do_reset();
    exp_q.push_back('{32'd0, 32'h0050_0513});
    s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h47};
    send_stream(s, 1'b0);
    end_check("bad_csum", 1'b0, 1'b1, 16'd1);

    // 6: full memory; each word repeats one byte so the checksum is 00
    do_reset();
    s = '{8'h40, 8'h00};
    for (int i = 0; i < 64; i++) begin
      v = 8'(i);
      exp_q.push_back('{32'(i * 4), {v, v, v, v}});
      for (int k = 0; k < 4; k++) s.push_back(v);
    end
    s.push_back(8'h00);
    send_stream(s, 1'b0);
    end_check("full_mem", 1'b1, 1'b0, 16'd64);

    // 7: reset mid-word, then a clean reload
    do_reset();
    s = '{8'h01, 8'h00, 8'h13, 8'h05};
    send_stream(s, 1'b0);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    check_reset_outputs("midrst_hold");
    rst = 1'b1;
    @(negedge clk);
    exp_q.push_back('{32'd0, 32'h0050_0513});
    s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h46};
    send_stream(s, 1'b0);
    end_check("reload", 1'b1, 1'b0, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
